ccw_engine: RTL

Upstream sequencer for the `channel` block: accepts one channel command word (CCW: device address, command, byte count, SLI flag) from the host, drives `channel`'s start/stop/addr/command inputs, and gates the host's byte streams through `channel`'s data AXI-Streams. It enforces the byte count, issues stop on overrun, and collects ending status. It reports one completion record per CCW.

---
 rtl/channel_pkg.sv | 20 ++
 rtl/ccw_engine_if.sv | 28 ++
 rtl/ccw_watchdog.sv | 24 ++
 rtl/ccw_engine.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// channel_pkg: shared FSM states, status bit and completion flag indices for ccw_engine
package channel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        INITIAL,
        TRANSFER,
        ENDING,
        DRAIN,
        DONE
    } state_t;

    localparam int STATUS_DE_BIT = 5;
    localparam int FLAG_IL       = 0;
    localparam int FLAG_OVERRUN  = 1;
    localparam int FLAG_TIMEOUT  = 2;
    localparam int CMD_DIR_BIT   = 0;

endpackage

// File: rtl/ccw_engine_if.sv
// ccw_engine_if: CCW command and completion handshakes between host and ccw_engine
interface ccw_engine_if #(
    parameter int COUNT_WIDTH = 16
);

    logic                   ccw_valid;
    logic                   ccw_ready;
    logic [7:0]             ccw_addr;
    logic [7:0]             ccw_command;
    logic [COUNT_WIDTH-1:0] ccw_count;
    logic                   ccw_sli;
    logic                   done_valid;
    logic                   done_ready;
    logic [7:0]             done_status;
    logic [COUNT_WIDTH-1:0] done_residual;
    logic [2:0]             done_flags;

    modport master (
        output ccw_valid, ccw_addr, ccw_command, ccw_count, ccw_sli, done_ready,
        input  ccw_ready, done_valid, done_status, done_residual, done_flags
    );

    modport slave (
        input  ccw_valid, ccw_addr, ccw_command, ccw_count, ccw_sli, done_ready,
        output ccw_ready, done_valid, done_status, done_residual, done_flags
    );

endinterface

// File: rtl/ccw_watchdog.sv
// ccw_watchdog: idle-cycle counter that expires after LIMIT cycles without progress
module ccw_watchdog #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // count idle cycles while running; any progress or leaving the run states restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= (run && !clear) ? cnt + W'(1) : '0;
    end

    assign expired = run && !clear && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/ccw_engine.sv
// ccw_engine: sequences one CCW through the channel block, gating data and collecting status.
// Optional watchdog enabled by defining CCW_ENGINE_TIMEOUT_EN.
module ccw_engine
    import channel_pkg::*;
#(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    ccw_engine_if.slave host,
    output logic [7:0] chan_addr,
    output logic [7:0] chan_command,
    output logic       chan_start,
    output logic       chan_stop,
    input  logic       chan_active,
    input  logic [7:0] chan_status_tdata,
    input  logic       chan_status_tvalid,
    output logic [7:0] chan_send_tdata,
    output logic       chan_send_tvalid,
    input  logic       chan_send_tready,
    input  logic [7:0] chan_recv_tdata,
    input  logic       chan_recv_tvalid,
    output logic       chan_recv_tready,
    input  logic [7:0] host_send_tdata,
    input  logic       host_send_tvalid,
    output logic       host_send_tready,
    output logic [7:0] host_recv_tdata,
    output logic       host_recv_tvalid,
    input  logic       host_recv_tready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [7:0]             status;
    logic                   sli, overrun;
    logic                   accept, write_dir, open_gate, xfer, busy, beat, de, overrun_req;
    logic                   overrun_any, timeout_hit;

    assign host.ccw_ready = (state == IDLE) && !chan_active;
    assign accept         = host.ccw_valid && host.ccw_ready;
    assign write_dir      = chan_command[CMD_DIR_BIT];
    assign open_gate      = (state == TRANSFER) && (count != '0);

    assign chan_send_tdata  = host_send_tdata;
    assign chan_send_tvalid = host_send_tvalid && open_gate && write_dir;
    assign host_send_tready = chan_send_tready && open_gate && write_dir;
    assign host_recv_tdata  = chan_recv_tdata;
    assign host_recv_tvalid = chan_recv_tvalid && open_gate && !write_dir;
    assign chan_recv_tready = host_recv_tready && open_gate && !write_dir;

    assign xfer        = (chan_send_tvalid && chan_send_tready) || (host_recv_tvalid && host_recv_tready);
    assign busy        = (state == INITIAL) || (state == TRANSFER) || (state == ENDING);
    assign beat        = busy && chan_status_tvalid;
    assign de          = chan_status_tdata[STATUS_DE_BIT];
    assign overrun_req = (state == TRANSFER) && (count == '0) && (write_dir ? chan_send_tready : chan_recv_tvalid);
    assign overrun_any = overrun || overrun_req;

`ifdef CCW_ENGINE_TIMEOUT_EN
    ccw_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (busy),
        .clear   (xfer || beat),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // next state; a status beat wins over an overrun in the same cycle, but the stop still fires
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = accept ? START : IDLE;
            START:    state_next = INITIAL;
            INITIAL:  if (beat) state_next = (chan_status_tdata == 8'h00 && chan_command != 8'h00) ? TRANSFER : DRAIN;
            TRANSFER: if (beat) state_next = de ? DRAIN : ENDING;
                      else if (overrun_req) state_next = ENDING;
            ENDING:   state_next = (beat && de) ? DRAIN : ENDING;
            DRAIN:    state_next = chan_active ? DRAIN : DONE;
            DONE:     state_next = host.done_ready ? IDLE : DONE;
            default:  state_next = IDLE;
        endcase
        if (timeout_hit) state_next = DONE;
    end

    // CCW latches, byte count, status capture, channel pulses and the completion record
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_addr          <= '0;
            chan_command       <= '0;
            chan_start         <= 1'b0;
            chan_stop          <= 1'b0;
            count              <= '0;
            status             <= '0;
            sli                <= 1'b0;
            overrun            <= 1'b0;
            host.done_valid    <= 1'b0;
            host.done_status   <= '0;
            host.done_residual <= '0;
            host.done_flags    <= '0;
        end else begin
            chan_start <= accept;
            chan_stop  <= overrun_req;
            if (accept) begin
                chan_addr    <= host.ccw_addr;
                chan_command <= host.ccw_command;
                count        <= host.ccw_count;
                sli          <= host.ccw_sli;
                overrun      <= 1'b0;
                status       <= '0;
            end else if (xfer) begin
                count <= count - COUNT_WIDTH'(1);
            end
            if (beat) status <= chan_status_tdata;
            if (overrun_req) overrun <= 1'b1;
            if (state_next == DONE && state != DONE) begin
                host.done_valid                 <= 1'b1;
                host.done_status                <= status;
                host.done_residual              <= count;
                host.done_flags[FLAG_IL]        <= ((count != '0) || overrun_any) && !sli;
                host.done_flags[FLAG_OVERRUN]   <= overrun_any;
                host.done_flags[FLAG_TIMEOUT]   <= timeout_hit;
            end else if (state == DONE && host.done_ready) begin
                host.done_valid <= 1'b0;
                chan_addr       <= '0;
                chan_command    <= '0;
            end
        end
    end

endmodule
